// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Instruction-fetch program counter and IF/ID pipeline register for a simple
// in-order pipeline. Selects the next fetch address from reset, EX-stage
// correction, interrupt entry, ID-stage static prediction or sequential
// increment. It also tracks the instruction memory handshake through a small
// BOOT/RUN/WAIT/INTR state machine.
//
// Parameters
//   RESET_PC           first fetch address after reset
//
// Ports
//   clk                single clock, rising-edge
//   rst                synchronous active-high reset
//   stall_if           hazard stall: holds the IF PC and the IF/ID register
//   id_taken           taken output of the ID-stage static predictor
//   id_redirection_pc  predictor target
//   ex_redirect        EX-stage mispredict / resolved-branch correction
//   ex_redirect_pc     correct target from EX
//   intr_req           level interrupt request
//   intr_vector        interrupt handler entry address
//   imem_ready         instruction memory returns data for imem_addr this cycle
//   imem_req           fetch request (registered, state decoded)
//   imem_addr          fetch address, identical to pc_if
//   pc_if              current fetch PC (registered)
//   pc_id              PC of the instruction held in ID
//   id_valid           ID holds a real instruction
//   flush_id           combinational squash of the ID stage
//   intr_ack           one-cycle interrupt-entry pulse
//   intr_epc           return PC captured on interrupt entry
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        id_taken,
  input  logic [31:0] id_redirection_pc,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_pc,
  input  logic        intr_req,
  input  logic [31:0] intr_vector,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_if,
  output logic [31:0] pc_id,
  output logic        id_valid,
  output logic        flush_id,
  output logic        intr_ack,
  output logic [31:0] intr_epc
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    INTR = 2'd3
  } state_t;

  state_t      state;

  logic        fetching;
  logic        advance;
  logic        intr_take;
  logic        id_redirect;
  logic [31:0] pc_next;

  // Instructions are at least halfword aligned: bit0 of any redirect target
  // is forced low, bit1 is left alone so compressed targets still work.
  function automatic logic [31:0] align_target(input logic [31:0] target);
    return {target[31:1], 1'b0};
  endfunction

  // ---------------------------------------------------------------------------
  // Control decode (combinational, current cycle)
  // ---------------------------------------------------------------------------
  assign fetching    = (state == RUN) || (state == WAIT);
  assign advance     = fetching && imem_ready && !stall_if;

  // Interrupts are only accepted from RUN, lose to an EX correction, and wait
  // out a hazard stall so the captured return PC is stable.
  assign intr_take   = intr_req && (state == RUN) && !ex_redirect && !stall_if;

  // A predicted-taken branch only counts when ID really holds an instruction.
  assign id_redirect = id_taken && id_valid && !stall_if;

  assign flush_id    = ex_redirect || intr_take;

  always_comb begin
    pc_next = pc_if;
    if (ex_redirect) begin
      pc_next = align_target(ex_redirect_pc);
    end else if (intr_take) begin
      pc_next = align_target(intr_vector);
    end else if (id_redirect) begin
      pc_next = align_target(id_redirection_pc);
    end else if (advance) begin
      pc_next = pc_if + 32'd4;
    end
  end

  // ---------------------------------------------------------------------------
  // IF stage: fetch PC register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_if <= RESET_PC;
    end else begin
      pc_if <= pc_next;
    end
  end

  assign imem_addr = pc_if;

  // ---------------------------------------------------------------------------
  // IF/ID boundary register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_id    <= 32'h0000_0000;
      id_valid <= 1'b0;
    end else if (flush_id) begin
      // Squash wins over advance; the stale PC is kept but marked invalid.
      id_valid <= 1'b0;
    end else if (id_redirect) begin
      // The branch moves on to EX; whatever was fetched alongside it is on
      // the wrong path, so ID becomes a bubble while pc_id is kept.
      id_valid <= 1'b0;
    end else if (advance) begin
      pc_id    <= pc_if;
      id_valid <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch state machine with registered request / interrupt outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      imem_req <= 1'b0;
      intr_ack <= 1'b0;
      intr_epc <= 32'h0000_0000;
    end else begin
      intr_ack <= intr_take;
      if (intr_take) begin
        intr_epc <= id_valid ? pc_id : pc_if;
      end

      unique case (state)
        BOOT: begin
          state    <= RUN;
          imem_req <= 1'b1;
        end
        RUN: begin
          if (intr_take) begin
            state    <= INTR;
            imem_req <= 1'b0;
          end else if (!imem_ready) begin
            // An EX redirect in this cycle still lands in pc_if; WAIT then
            // simply re-requests at the new address.
            state    <= WAIT;
            imem_req <= 1'b1;
          end else begin
            state    <= RUN;
            imem_req <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_ready) begin
            state <= RUN;
          end
          imem_req <= 1'b1;
        end
        INTR: begin
          state    <= RUN;
          imem_req <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
//
// Directed bench for fetch_pc_unit. The stimulus process drives one cycle at
// a time and pushes the hand-computed values expected in that cycle into a
// scoreboard queue; an independent monitor on the falling edge pops entries
// for the current cycle and compares them against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0010;

  localparam int F_PC    = 0;
  localparam int F_PCID  = 1;
  localparam int F_VLD   = 2;
  localparam int F_REQ   = 3;
  localparam int F_ACK   = 4;
  localparam int F_EPC   = 5;
  localparam int F_FLUSH = 6;
  localparam int F_ADDR  = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if;
  logic        id_taken;
  logic [31:0] id_redirection_pc;
  logic        ex_redirect;
  logic [31:0] ex_redirect_pc;
  logic        intr_req;
  logic [31:0] intr_vector;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc_if;
  logic [31:0] pc_id;
  logic        id_valid;
  logic        flush_id;
  logic        intr_ack;
  logic [31:0] intr_epc;

  fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_if          (stall_if),
    .id_taken          (id_taken),
    .id_redirection_pc (id_redirection_pc),
    .ex_redirect       (ex_redirect),
    .ex_redirect_pc    (ex_redirect_pc),
    .intr_req          (intr_req),
    .intr_vector       (intr_vector),
    .imem_ready        (imem_ready),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .pc_if             (pc_if),
    .pc_id             (pc_id),
    .id_valid          (id_valid),
    .flush_id          (flush_id),
    .intr_ack          (intr_ack),
    .intr_epc          (intr_epc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          cyc;
    int          field;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] actual(input int f);
    case (f)
      F_PC:    return pc_if;
      F_PCID:  return pc_id;
      F_VLD:   return {31'd0, id_valid};
      F_REQ:   return {31'd0, imem_req};
      F_ACK:   return {31'd0, intr_ack};
      F_EPC:   return intr_epc;
      F_FLUSH: return {31'd0, flush_id};
      default: return imem_addr;
    endcase
  endfunction

  // Monitor: every cycle the DUT presents its outputs; compare whatever the
  // stimulus queued for this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      checks++;
      if (cur.cyc != cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", cur.name, cur.cyc, cyc);
      end else if (actual(cur.field) !== cur.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", cur.name, actual(cur.field), cur.val, cyc);
      end
    end
  end

  task automatic e(input string n, input int f, input logic [31:0] v);
    exp_t x;
    x.name  = n;
    x.cyc   = cyc;
    x.field = f;
    x.val   = v;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stall_if = 1'b0; id_taken = 1'b0; id_redirection_pc = '0;
    ex_redirect = 1'b0; ex_redirect_pc = '0; intr_req = 1'b0;
    intr_vector = '0; imem_ready = 1'b1;
    tick(); tick();

    // Reset state and sequential fetch from RESET_PC
    rst = 1'b0;
    e("rst_pc_if", F_PC, RST_PC);   e("rst_pc_id", F_PCID, 32'h0);
    e("rst_id_valid", F_VLD, 0);    e("rst_imem_req", F_REQ, 0);
    e("rst_intr_ack", F_ACK, 0);    e("rst_intr_epc", F_EPC, 32'h0);
    tick();
    e("run_pc_if0", F_PC, RST_PC);  e("run_imem_req", F_REQ, 1);
    e("run_id_valid0", F_VLD, 0);   e("run_addr", F_ADDR, RST_PC);
    tick();
    e("seq_pc_if1", F_PC, 32'h14);  e("seq_id_valid1", F_VLD, 1);
    e("seq_pc_id1", F_PCID, 32'h10);
    tick();
    e("seq_pc_if2", F_PC, 32'h18);  e("seq_pc_id2", F_PCID, 32'h14);

    // EX redirect to 0x101 (bit0 cleared) to place a branch at 0x100
    ex_redirect = 1'b1; ex_redirect_pc = 32'h101;
    e("exr_flush", F_FLUSH, 1);
    tick();
    ex_redirect = 1'b0;
    e("exr_pc_if", F_PC, 32'h100);  e("exr_id_valid", F_VLD, 0);
    e("exr_pc_id_hold", F_PCID, 32'h14);
    tick();
    e("br_pc_id", F_PCID, 32'h100); e("br_id_valid", F_VLD, 1);

    // ID-stage predicted taken, target 0x0F1 -> 0x0F0
    id_taken = 1'b1; id_redirection_pc = 32'h0F1;
    e("pred_no_flush", F_FLUSH, 0);
    tick();
    e("pred_pc_if", F_PC, 32'h0F0); e("pred_id_valid", F_VLD, 0);
    e("pred_pc_id_hold", F_PCID, 32'h100);
    tick(); // id_taken still high but id_valid=0: ignored
    id_taken = 1'b0;
    e("pred_ign_pc_if", F_PC, 32'h0F4); e("pred_ign_pc_id", F_PCID, 32'h0F0);

    // Simultaneous ex_redirect, id_taken and intr_req: EX wins
    ex_redirect = 1'b1; ex_redirect_pc = 32'h200; id_taken = 1'b1;
    id_redirection_pc = 32'h500; intr_req = 1'b1; intr_vector = 32'h80;
    e("prio_flush", F_FLUSH, 1);
    tick();
    ex_redirect = 1'b0; id_taken = 1'b0; intr_req = 1'b0;
    e("prio_pc_if", F_PC, 32'h200); e("prio_intr_ack", F_ACK, 0);
    e("prio_imem_req", F_REQ, 1);   e("prio_id_valid", F_VLD, 0);
    e("prio_epc", F_EPC, 32'h0);
    tick();

    // Interrupt entry with pc_id=0x40 valid
    ex_redirect = 1'b1; ex_redirect_pc = 32'h40;
    tick();
    ex_redirect = 1'b0;
    tick();
    e("irq_pre_pc_id", F_PCID, 32'h40); e("irq_pre_vld", F_VLD, 1);
    intr_req = 1'b1; intr_vector = 32'h81;
    e("irq_flush", F_FLUSH, 1);
    tick(); // now in INTR, intr_req still high and must be ignored
    e("irq_ack", F_ACK, 1);         e("irq_epc", F_EPC, 32'h40);
    e("irq_pc_if", F_PC, 32'h80);   e("irq_id_valid", F_VLD, 0);
    e("irq_imem_req", F_REQ, 0);    e("irq_ignored_flush", F_FLUSH, 0);
    tick();
    intr_req = 1'b0;
    e("irq_ack_once", F_ACK, 0);    e("irq_resume_req", F_REQ, 1);
    e("irq_hold_pc_if", F_PC, 32'h80);
    tick();
    e("irq_adv_pc_if", F_PC, 32'h84); e("irq_adv_pc_id", F_PCID, 32'h80);

    // Stall defers id_taken and interrupt
    stall_if = 1'b1; id_taken = 1'b1; id_redirection_pc = 32'h300; intr_req = 1'b1;
    e("stall_no_intr", F_FLUSH, 0);
    tick();
    intr_req = 1'b0;
    e("stall_pc_if1", F_PC, 32'h84); e("stall_id_valid", F_VLD, 1);
    e("stall_no_ack", F_ACK, 0);
    tick();
    stall_if = 1'b0;
    e("stall_pc_if2", F_PC, 32'h84); e("stall_pc_id", F_PCID, 32'h80);
    tick();
    id_taken = 1'b0;
    e("unstall_pc_if", F_PC, 32'h300); e("unstall_vld", F_VLD, 0);
    tick();

    // EX redirect under stall, then wrap from 0xFFFF_FFFC
    stall_if = 1'b1; ex_redirect = 1'b1; ex_redirect_pc = 32'hFFFF_FFFD;
    e("stall_ex_flush", F_FLUSH, 1);
    tick();
    stall_if = 1'b0; ex_redirect = 1'b0;
    e("stall_ex_pc_if", F_PC, 32'hFFFF_FFFC);
    tick();
    e("wrap_pc_if", F_PC, 32'h0);   e("wrap_pc_id", F_PCID, 32'hFFFF_FFFC);

    // WAIT: imem_ready low for three cycles, EX redirect in the second
    ex_redirect = 1'b1; ex_redirect_pc = 32'h10;
    tick();
    ex_redirect = 1'b0; imem_ready = 1'b0;
    e("w1_pc_if", F_PC, 32'h10);
    tick();
    ex_redirect = 1'b1; ex_redirect_pc = 32'h300;
    e("w2_pc_if", F_PC, 32'h10);    e("w2_req", F_REQ, 1);
    tick();
    ex_redirect = 1'b0;
    e("w3_pc_if", F_PC, 32'h300);   e("w3_req", F_REQ, 1);
    e("w3_addr", F_ADDR, 32'h300);
    tick();
    imem_ready = 1'b1;
    e("w4_pc_if", F_PC, 32'h300);   e("w4_vld", F_VLD, 0);
    tick();
    e("resume_pc_if", F_PC, 32'h304); e("resume_pc_id", F_PCID, 32'h300);

    // bit1 of a redirect target passes through
    ex_redirect = 1'b1; ex_redirect_pc = 32'h407;
    tick();
    ex_redirect = 1'b0; imem_ready = 1'b0;
    e("bit1_pc_if", F_PC, 32'h406);
    tick();

    // Reset in WAIT with pending redirect and interrupt
    rst = 1'b1; ex_redirect = 1'b1; ex_redirect_pc = 32'h900; intr_req = 1'b1;
    tick();
    rst = 1'b0; ex_redirect = 1'b0; intr_req = 1'b0; imem_ready = 1'b1;
    e("mrst_pc_if", F_PC, RST_PC);  e("mrst_req", F_REQ, 0);
    e("mrst_vld", F_VLD, 0);        e("mrst_pc_id", F_PCID, 32'h0);
    e("mrst_ack", F_ACK, 0);        e("mrst_epc", F_EPC, 32'h0);
    tick();
    e("mrst_run_pc_if", F_PC, RST_PC); e("mrst_run_req", F_REQ, 1);
    tick();
    tick();

    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL scoreboard: %0d expectations never checked", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port stall_if, input, 1 bit: hazard-unit stall; holds the IF PC and the IF/ID register.
REQ-005 SHALL have port id_taken, input, 1 bit: taken output of the ID-stage static predictor.
REQ-006 SHALL have port id_redirection_pc, input, 32 bits: predictor target.
REQ-007 SHALL have port ex_redirect, input, 1 bit: EX-stage mispredict or resolved-branch correction.
REQ-008 SHALL have port ex_redirect_pc, input, 32 bits: correct target from EX.
REQ-009 SHALL have port intr_req, input, 1 bit: level interrupt request.
REQ-010 SHALL have port intr_vector, input, 32 bits: handler entry address.
REQ-011 SHALL have port imem_ready, input, 1 bit: instruction memory returns data for imem_addr this cycle.
REQ-012 SHALL have port imem_req, output, 1 bit: fetch request.
REQ-013 SHALL have port imem_addr, output, 32 bits: equals pc_if.
REQ-014 SHALL have port pc_if, output, 32 bits: current fetch PC.
REQ-015 SHALL have port pc_id, output, 32 bits: PC of the instruction in ID.
REQ-016 SHALL have port id_valid, output, 1 bit: ID holds a real instruction.
REQ-017 SHALL have port flush_id, output, 1 bit: combinational squash of ID.
REQ-018 SHALL have port intr_ack, output, 1 bit: one-cycle interrupt-entry pulse.
REQ-019 SHALL have port intr_epc, output, 32 bits: return PC captured on interrupt entry.

Function
REQ-020 SHALL implement FSM states BOOT, RUN, WAIT, INTR.
REQ-021 BOOT: imem_req=0; next state RUN unconditionally.
REQ-022 RUN and WAIT: imem_req=1; INTR: imem_req=0.
REQ-023 "advance" SHALL be defined as state in {RUN, WAIT} & imem_ready & !stall_if.
REQ-024 next pc_if priority, highest first:
- rst -> RESET_PC
- ex_redirect -> ex_redirect_pc
- intr_take -> intr_vector
- id_taken & id_valid & !stall_if -> id_redirection_pc
- advance -> pc_if+4, modulo 2^32
- else hold
REQ-025 Every redirect target SHALL have bit0 cleared; bit1 passes unchanged.
REQ-026 intr_take SHALL be defined as intr_req & state==RUN & !ex_redirect.
- Next state is INTR.
- intr_ack=1 for exactly that one cycle.
- intr_epc <= pc_id if id_valid, else pc_if.
REQ-027 INTR SHALL go to RUN after one cycle; intr_req SHALL be ignored while in INTR and BOOT.
REQ-028 RUN -> WAIT when imem_req & !imem_ready; WAIT -> RUN when imem_ready.
- ex_redirect in WAIT SHALL still update pc_if.
- The new address is presented the next cycle; the pending fetch is abandoned.
REQ-029 IF/ID register on advance: pc_id <= pc_if; id_valid <= 1.
REQ-030 In any cycle without advance and without flush, pc_id and id_valid SHALL hold.
REQ-031 flush_id SHALL equal ex_redirect | intr_take; when flush_id=1, id_valid <= 0 regardless of advance.
REQ-032 When id_taken & id_valid & !stall_if and not flushed:
- The branch in ID proceeds.
- The same-cycle fetch is wrong-path, so id_valid <= 0 next cycle.
- pc_id SHALL hold.
REQ-033 id_taken with id_valid=0 SHALL be ignored.
REQ-034 ex_redirect SHALL take effect even when stall_if=1.
REQ-035 id_taken and intr_take SHALL be deferred while stall_if=1.
REQ-036 imem_addr and pc_if SHALL be registered outputs with zero combinational path from imem_ready.

Reset
REQ-037 On rst:
- pc_if=RESET_PC; pc_id=0; id_valid=0.
- intr_ack=0; intr_epc=0; state=BOOT.
- imem_req=0 in the following cycle.
REQ-038 rst asserted mid-operation, including in WAIT or INTR, SHALL override every other input and discard the pending redirect or interrupt.

Verification
REQ-039 Reset then imem_ready=1 constant:
- pc_if sequence RESET_PC, RESET_PC, +4, +8.
- id_valid rises the cycle after the first advance.
REQ-040 pc_id=0x100 valid, id_taken=1, id_redirection_pc=0x0F1:
- Next pc_if=0x0F0; id_valid=0 for one cycle.
- pc_id=0x100 held.
REQ-041 Same cycle ex_redirect=1 (0x200), id_taken=1, intr_req=1:
- pc_if=0x200; flush_id=1; intr_ack=0.
REQ-042 intr_req=1 in RUN, pc_id=0x40 valid, intr_vector=0x80:
- intr_ack pulses once; intr_epc=0x40; pc_if=0x80.
- id_valid=0; imem_req=0 for one cycle.
REQ-043 imem_ready=0 for 3 cycles at pc_if=0x10:
- State WAIT; pc_if holds 0x10.
- ex_redirect to 0x300 in cycle 2 -> pc_if=0x300; resumes on imem_ready.
REQ-044 pc_if=0xFFFF_FFFC advancing SHALL wrap to 0x0000_0000; stall_if=1 with id_taken=1 -> no redirect until stall drops.
